// File: rtl/muldiv_div_responder_pkg.sv
// Shared types for the divider lane: lane state, divide op codes and decode helpers.
package muldiv_div_responder_pkg;

    typedef enum logic [1:0] {
        StFree     = 2'd0,
        StReserved = 2'd1,
        StBusy     = 2'd2,
        StFinished = 2'd3
    } div_lane_state_e;

    typedef enum logic [1:0] {
        DivDiv  = 2'd0,
        DivDivu = 2'd1,
        DivRem  = 2'd2,
        DivRemu = 2'd3
    } int_div_code_e;

    function automatic logic is_signed_op(int_div_code_e code);
        return (code == DivDiv) || (code == DivRem);
    endfunction

    function automatic logic is_rem_op(int_div_code_e code);
        return (code == DivRem) || (code == DivRemu);
    endfunction

endpackage

// File: rtl/muldiv_div_responder_radix2.sv
// Radix-2 restoring divider: operand latch, one step per step_i, RISC-V corner cases and
// sign fixup on the final step. Special cases resolve on start without iterating.
module muldiv_div_responder_radix2
    import muldiv_div_responder_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = $clog2(DataWidth) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 start_i,
    input  logic                 step_i,
    input  int_div_code_e        code_i,
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    output logic                 special_o,
    output logic                 done_o,
    output logic [DataWidth-1:0] result_o
);
    localparam int unsigned          DivIterationNum = DataWidth;
    localparam logic [CntWidth-1:0]  LastCnt = CntWidth'(DivIterationNum - 1);
    localparam logic [DataWidth-1:0] MinVal  = {1'b1, {(DataWidth - 1){1'b0}}};

    logic                 sgn, a_neg, b_neg, div_zero, ovf, fits, last_step;
    logic [DataWidth-1:0] a_mag, b_mag, special_res;
    logic [DataWidth:0]   shifted, diff;
    logic [DataWidth-1:0] rem_nx, quo_nx, fix_quo, fix_rem;

    logic [DataWidth-1:0] rem_q, rem_d, quo_q, quo_d, bmag_q, bmag_d, result_q, result_d;
    logic                 neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, rem_op_q, rem_op_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;

    always_comb begin
        sgn       = is_signed_op(code_i);
        a_neg     = sgn & a_i[DataWidth-1];
        b_neg     = sgn & b_i[DataWidth-1];
        a_mag     = a_neg ? ('0 - a_i) : a_i;
        b_mag     = b_neg ? ('0 - b_i) : b_i;
        div_zero  = (b_i == '0);
        ovf       = sgn && (a_i == MinVal) && (b_i == '1);
        special_o = div_zero | ovf;
        if (div_zero) begin
            special_res = is_rem_op(code_i) ? a_i : '1;
        end else begin
            special_res = is_rem_op(code_i) ? '0 : MinVal;
        end

        // The shifted partial remainder needs one extra bit before the trial subtract.
        shifted   = {rem_q, quo_q[DataWidth-1]};
        diff      = shifted - {1'b0, bmag_q};
        fits      = ~diff[DataWidth];
        rem_nx    = fits ? diff[DataWidth-1:0] : shifted[DataWidth-1:0];
        quo_nx    = {quo_q[DataWidth-2:0], fits};
        fix_quo   = neg_quo_q ? ('0 - quo_nx) : quo_nx;
        fix_rem   = neg_rem_q ? ('0 - rem_nx) : rem_nx;
        last_step = (cnt_q == LastCnt);
        done_o    = step_i & last_step;
        result_o  = result_q;
    end

    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        bmag_d    = bmag_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_op_d  = rem_op_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d    = '0;
            rem_op_d = is_rem_op(code_i);
            if (special_o) begin
                result_d = special_res;
            end else begin
                rem_d     = '0;
                quo_d     = a_mag;
                bmag_d    = b_mag;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
            end
        end else if (step_i) begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + CntWidth'(1);
            if (last_step) begin
                result_d = rem_op_q ? fix_rem : fix_quo;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q     <= '0;
            quo_q     <= '0;
            bmag_q    <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_op_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            bmag_q    <= bmag_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_op_q  <= rem_op_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/muldiv_div_responder.sv
// Divider lane responder: reservation FSM, owner pointer and status outputs around the
// radix-2 divider core.
module muldiv_div_responder
    import muldiv_div_responder_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned AlPtrWidth = 7,
    parameter int unsigned CntWidth   = $clog2(DataWidth) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  acquire_i,
    input  logic [AlPtrWidth-1:0] acquire_ptr_i,
    input  logic                  req_i,
    input  logic [1:0]            code_i,
    input  logic [DataWidth-1:0]  data_a_i,
    input  logic [DataWidth-1:0]  data_b_i,
    input  logic                  release_i,
    output logic                  free_o,
    output logic                  reserved_o,
    output logic                  busy_o,
    output logic                  finished_o,
    output logic [AlPtrWidth-1:0] owner_ptr_o,
    output logic [DataWidth-1:0]  data_out_o
);
    div_lane_state_e       state_q, state_d;
    logic [AlPtrWidth-1:0] owner_q, owner_d;
    logic                  core_start, core_step, core_special, core_done;

    assign core_start = (state_q == StReserved) && req_i && !flush_i;
    assign core_step  = (state_q == StBusy) && !flush_i;

    muldiv_div_responder_radix2 #(
        .DataWidth (DataWidth),
        .CntWidth  (CntWidth)
    ) u_core (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .start_i   (core_start),
        .step_i    (core_step),
        .code_i    (int_div_code_e'(code_i)),
        .a_i       (data_a_i),
        .b_i       (data_b_i),
        .special_o (core_special),
        .done_o    (core_done),
        .result_o  (data_out_o)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (flush_i) begin
            state_d = StFree;
        end else begin
            unique case (state_q)
                StFree: begin
                    if (acquire_i) begin
                        state_d = StReserved;
                        owner_d = acquire_ptr_i;
                    end
                end
                StReserved: begin
                    if (req_i) begin
                        state_d = core_special ? StFinished : StBusy;
                    end
                end
                StBusy: begin
                    if (core_done) begin
                        state_d = StFinished;
                    end
                end
                StFinished: begin
                    // Release with a fresh acquire hands the lane straight to the new owner.
                    if (release_i) begin
                        if (acquire_i) begin
                            state_d = StReserved;
                            owner_d = acquire_ptr_i;
                        end else begin
                            state_d = StFree;
                        end
                    end
                end
                default: state_d = StFree;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFree;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign free_o      = (state_q == StFree);
    assign reserved_o  = (state_q != StFree);
    assign busy_o      = (state_q == StBusy);
    assign finished_o  = (state_q == StFinished);
    assign owner_ptr_o = owner_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StFree && !flush_i) |-> !(req_i || release_i));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == StReserved && !flush_i) |-> !acquire_i);

endmodule

// File: tb/tb_muldiv_div_responder.sv
// Self-checking bench for the divider lane responder: vector table plus handshake corner cases.
module tb_muldiv_div_responder;
    localparam int unsigned W = 32;
    localparam int unsigned P = 7;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic         flush_i = 1'b0, acquire_i = 1'b0, req_i = 1'b0, release_i = 1'b0;
    logic [P-1:0] acquire_ptr_i = '0;
    logic [1:0]   code_i = '0;
    logic [W-1:0] data_a_i = '0, data_b_i = '0;
    logic         free_o, reserved_o, busy_o, finished_o;
    logic [P-1:0] owner_ptr_o;
    logic [W-1:0] data_out_o;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct packed {
        logic [1:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         special;
    } vec_t;

    vec_t vecs[16];

    muldiv_div_responder #(
        .DataWidth  (W),
        .AlPtrWidth (P)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .acquire_i     (acquire_i),
        .acquire_ptr_i (acquire_ptr_i),
        .req_i         (req_i),
        .code_i        (code_i),
        .data_a_i      (data_a_i),
        .data_b_i      (data_b_i),
        .release_i     (release_i),
        .free_o        (free_o),
        .reserved_o    (reserved_o),
        .busy_o        (busy_o),
        .finished_o    (finished_o),
        .owner_ptr_o   (owner_ptr_o),
        .data_out_o    (data_out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_free"}, W'(free_o), 1);
        check({tag, "_reserved"}, W'(reserved_o), 0);
        check({tag, "_busy"}, W'(busy_o), 0);
        check({tag, "_finished"}, W'(finished_o), 0);
        check({tag, "_owner"}, W'(owner_ptr_o), 0);
        check({tag, "_data_out"}, data_out_o, 0);
    endtask

    // Pop the scoreboard and compare against the value the lane is presenting now.
    task automatic score(output logic [W-1:0] e);
        e = 'x;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got result %h expected none pending", data_out_o);
        end else begin
            e = exp_q.pop_front();
            check("data_out", data_out_o, e);
        end
    endtask

    task automatic run_op(input logic [P-1:0] ptr, input vec_t v);
        int cyc;
        int busy_cnt;
        logic [W-1:0] e;
        acquire_i     = 1'b1;
        acquire_ptr_i = ptr;
        step();
        acquire_i = 1'b0;
        check("reserved_after_acquire", W'(reserved_o), 1);
        check("free_after_acquire", W'(free_o), 0);
        check("owner_ptr", W'(owner_ptr_o), W'(ptr));
        code_i   = v.code;
        data_a_i = v.a;
        data_b_i = v.b;
        req_i    = 1'b1;
        exp_q.push_back(v.res);
        step();
        req_i    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (!finished_o && cyc < 100) begin
            if (busy_o) busy_cnt++;
            step();
            cyc++;
        end
        check("latency", W'(cyc), v.special ? 1 : 33);
        check("busy_cycles", W'(busy_cnt), v.special ? 0 : 32);
        score(e);
        step();
        check("finished_hold", W'(finished_o), 1);
        check("data_out_hold", data_out_o, e);
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        check("free_after_release", W'(free_o), 1);
        check("finished_after_release", W'(finished_o), 0);
        check("data_out_kept", data_out_o, e);
    endtask

    initial begin
        int fin_seen;
        int cyc;
        logic [W-1:0] e;

        vecs[0]  = '{2'd0, 32'd100, 32'd7, 32'd14, 1'b0};
        vecs[1]  = '{2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 1'b0};
        vecs[3]  = '{2'd1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{2'd2, 32'd1234, 32'd0, 32'd1234, 1'b1};
        vecs[5]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[6]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1};
        vecs[7]  = '{2'd0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0};
        vecs[8]  = '{2'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0};
        vecs[9]  = '{2'd0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
        vecs[10] = '{2'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b0};
        vecs[11] = '{2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[12] = '{2'd2, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 1'b0};
        vecs[13] = '{2'd0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1'b1};
        vecs[14] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[15] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};

        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("reset");
        #9 rst_ni = 1'b1;
        step();
        check_reset_outputs("post_reset");

        for (int i = 0; i < 16; i++) begin
            run_op(P'(5 + i), vecs[i]);
        end

        // Flush part-way through an iteration: the lane frees and never reports a result.
        acquire_i     = 1'b1;
        acquire_ptr_i = 7'd3;
        step();
        acquire_i = 1'b0;
        code_i    = 2'd0;
        data_a_i  = 32'd100;
        data_b_i  = 32'd7;
        req_i     = 1'b1;
        step();
        req_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("busy_before_flush", W'(busy_o), 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("free_after_flush", W'(free_o), 1);
        check("busy_after_flush", W'(busy_o), 0);
        fin_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (finished_o) fin_seen++;
            step();
        end
        check("finished_after_flush", W'(fin_seen), 0);
        check("data_out_after_flush", data_out_o, vecs[15].res);
        run_op(7'd4, '{2'd1, 32'd9, 32'd3, 32'd3, 1'b0});

        // Back-to-back reuse: release and acquire in the same FINISHED cycle.
        acquire_i     = 1'b1;
        acquire_ptr_i = 7'd2;
        step();
        acquire_i = 1'b0;
        code_i    = 2'd0;
        data_a_i  = 32'd100;
        data_b_i  = 32'd7;
        req_i     = 1'b1;
        exp_q.push_back(32'd14);
        step();
        req_i = 1'b0;
        cyc   = 1;
        while (!finished_o && cyc < 100) begin
            step();
            cyc++;
        end
        check("b2b_latency", W'(cyc), 33);
        score(e);
        release_i     = 1'b1;
        acquire_i     = 1'b1;
        acquire_ptr_i = 7'd9;
        step();
        release_i = 1'b0;
        acquire_i = 1'b0;
        check("b2b_reserved", W'(reserved_o), 1);
        check("b2b_owner", W'(owner_ptr_o), 9);
        check("b2b_finished", W'(finished_o), 0);
        check("b2b_busy", W'(busy_o), 0);
        check("b2b_data_out", data_out_o, 32'd14);

        // Asynchronous reset in the middle of an iteration.
        code_i   = 2'd1;
        data_a_i = 32'd1000;
        data_b_i = 32'd10;
        req_i    = 1'b1;
        step();
        req_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("busy_before_reset", W'(busy_o), 1);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("mid_busy_reset");
        #1 rst_ni = 1'b1;
        step();
        check_reset_outputs("after_mid_busy_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
